muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit sitting directly downstream of the register file read ports.
- Consumes the two source operands, computes a 64-bit product or a quotient/remainder over WIDTH cycles, and holds the result in internal HI/LO registers.
- The control FSM stalls on busy. It moves hi/lo to the register file write port (DATAin) with MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width. Iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only when the unit is ready
- op  input  2  00 MULTU, 01 DIVU, 10 MULT, 11 DIV
- a  input  WIDTH  operand A: multiplicand / dividend (RS value)
- b  input  WIDTH  operand B: multiplier / divisor (RT value)
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when hi/lo are updated
- hi  output  WIDTH  product upper half / remainder
- lo  output  WIDTH  product lower half / quotient
- div_by_zero  output  1  set with done when a divide had b==0

Behaviour:
- Reset (async, rst=1): state IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; all internal accumulators and counters cleared.
- Reset mid-operation aborts the operation. Previous hi/lo values are lost (both cleared to 0).
- FSM states: IDLE, CALC, DONE.
  - Ready: state is IDLE or DONE.
  - IDLE -> CALC: start=1 at an edge while ready. At that edge, latch a, b and op, clear the accumulator, and load the counter with WIDTH.
  - CALC: one iteration per edge; counter decrements.
  - CALC -> DONE: on the edge that completes iteration WIDTH. At this same edge hi/lo/div_by_zero are written.
  - DONE -> IDLE: next edge, unless start=1. With start=1 the unit goes DONE -> CALC, giving back-to-back operation.
- Outputs by state:
  - busy = (state==CALC). It is high in the cycle after start is accepted.
  - done = (state==DONE). It is exactly one cycle wide per operation.
- Latency: start accepted at edge E. Iterations occur at edges E+1..E+WIDTH. done is high in the cycle after edge E+WIDTH, i.e. WIDTH+1 edges after acceptance (33 for WIDTH=32).
- start while busy is ignored; it is not queued. Operand changes during CALC have no effect.
- hi/lo hold their value between operations. Partial results are never visible on hi/lo.
- Multiply: shift-add, one multiplier bit per cycle. {hi,lo} = a*b, full 2*WIDTH-bit result, no truncation.
- Divide: restoring, one quotient bit per cycle. lo = a/b, hi = a%b.
- Divide by zero:
  - Iterations still run the full WIDTH cycles; latency is unchanged.
  - Result is lo = all ones, hi = a. div_by_zero=1.
- div_by_zero updates only at completion: it is set by a divide with b==0 and cleared by any other completing operation.
- MULT/MULTU never set div_by_zero.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined, op[1]=1 selects signed arithmetic:
  - Operands are converted to magnitudes at accept; the result sign is fixed in the final cycle with no extra latency.
  - Product sign = sign(a) XOR sign(b).
  - Quotient truncates toward zero; remainder takes the sign of a.
  - Overflow case a=0x80000000, b=0xFFFFFFFF with DIV: lo=0x80000000, hi=0.
  - Signed divide by zero: lo=all ones, hi=a, div_by_zero=1.
- Not defined: op[1] is ignored; MULT behaves as MULTU and DIV as DIVU. No sign logic is synthesised.

Test Plan:
- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy for 32 cycles; done at edge 33 after accept; hi=0xFFFFFFFE, lo=0x00000001.
- DIVU a=100 b=7 -> lo=14, hi=2, div_by_zero=0. Issue a second start during busy -> ignored; exactly one done pulse.
- DIVU a=0x12345678 b=0 -> latency 33; lo=0xFFFFFFFF, hi=0x12345678, div_by_zero=1. Following MULTU 3*5 -> lo=15, hi=0, div_by_zero=0.
- Back-to-back: start held high in the DONE cycle -> next op accepted with no IDLE cycle; done pulses spaced 33 cycles apart.
- Assert rst at CALC cycle 10 of MULTU 6*7 -> busy=0, done=0, hi=lo=0 immediately; no done pulse afterwards.
- With MULDIV_SIGNED_EN:
  - MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Without MULDIV_SIGNED_EN: MULT -3*5 -> lo=0xFFFFFFF1, hi=0x00000004 (unsigned result).

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiply / restoring divide into HI/LO; signed ops enabled by MULDIV_SIGNED_EN
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state, state_nx;
    logic [2*WIDTH-1:0]   p, p_nx, res;
    logic [WIDTH-1:0]     m, a_in, b_in;
    logic [CW-1:0]        cnt;
    logic [WIDTH:0]       sum, shifted, diff;
    logic                 is_div, dz, accept, last;

    assign accept = start && state != CALC;
    assign last   = cnt == CW'(1);
    assign busy   = state == CALC;
    assign done   = state == DONE;

`ifdef MULDIV_SIGNED_EN
    logic neg_q, neg_r;

    // Signed ops iterate on magnitudes; signs are captured separately at accept
    always_comb begin
        a_in = (op[1] && a[WIDTH-1]) ? -a : a;
        b_in = (op[1] && b[WIDTH-1]) ? -b : b;
    end

    // Re-apply signs on the final write; a zero divisor forces an all-ones quotient
    always_comb begin
        res = is_div ? {neg_r ? -p_nx[2*WIDTH-1:WIDTH] : p_nx[2*WIDTH-1:WIDTH],
                        dz ? {WIDTH{1'b1}} : neg_q ? -p_nx[WIDTH-1:0] : p_nx[WIDTH-1:0]}
                     : (neg_q ? -p_nx : p_nx);
    end
`else
    logic unused_op;

    assign unused_op = op[1];
    assign a_in      = a;
    assign b_in      = b;
    assign res       = p_nx;
`endif

    // One iteration: p holds {partial, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        sum     = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
        shifted = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        diff    = shifted - {1'b0, m};
        p_nx    = !is_div ? {sum, p[WIDTH-1:1]}
                : diff[WIDTH] ? {shifted[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
                : {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state: accept from IDLE/DONE, leave CALC after the last iteration
    always_comb begin
        state_nx = accept ? CALC : (state == CALC && !last) ? CALC : (state == CALC) ? DONE : IDLE;
    end

    // Datapath: latch operands on accept, iterate in CALC, publish results on the last edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p           <= '0;
            m           <= '0;
            cnt         <= '0;
            is_div      <= 1'b0;
            dz          <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else if (accept) begin
            p      <= {{WIDTH{1'b0}}, a_in};
            m      <= b_in;
            cnt    <= CW'(WIDTH);
            is_div <= op[0];
            dz     <= b == '0;
`ifdef MULDIV_SIGNED_EN
            neg_q  <= op[1] && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= op[1] && a[WIDTH-1];
`endif
        end else if (state == CALC) begin
            p   <= p_nx;
            cnt <= cnt - CW'(1);
            if (last) begin
                hi          <= res[2*WIDTH-1:WIDTH];
                lo          <= res[WIDTH-1:0];
                div_by_zero <= is_div && dz;
            end
        end
    end
endmodule
